sram_port_arbiter: RTL

//   Shares one single-port SRAM macro (the sram_wrapper instance behind the memory subsystem) between

---
 rtl/sram_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumPorts req/gnt requesters.
// Optional per-port bus locking is compiled in with `define SRAM_ARB_LOCK_EN.
module sram_port_arbiter #(
    parameter int NumPorts      = 2,
    parameter int AddrWidth     = 13,
    parameter int DataWidth     = 64,
    parameter int MaxLockCycles = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0] be_i,
`ifdef SRAM_ARB_LOCK_EN
    input  logic [NumPorts-1:0]             lock_i,
`endif
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
);
    localparam int BeWidth = DataWidth / 8;
    localparam int PtrW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]     win_idx;
    logic [PtrW-1:0]     rid_q;
    logic                rvalid_q;
    logic                any_gnt;
    logic [NumPorts-1:0] eligible;
    int unsigned         cand;

`ifdef SRAM_ARB_LOCK_EN
    localparam int CntW = $clog2(MaxLockCycles + 1);

    typedef enum logic {IDLE, LOCKED} lock_state_e;

    lock_state_e     state_q, state_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            locked;

    // An owner dropping lock_i releases the bus in the same cycle.
    assign locked   = (state_q == LOCKED) && lock_i[owner_q];
    assign eligible = locked ? (NumPorts'(1) << owner_q) : '1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (state_q == LOCKED && !lock_i[owner_q]) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        if (any_gnt) begin
            if (locked) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CntW'(MaxLockCycles)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end else if (lock_i[win_idx] && MaxLockCycles > 1) begin
                state_d = LOCKED;
                owner_d = win_idx;
                cnt_d   = CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign eligible = '1;
`endif

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        gnt_o   = '0;
        any_gnt = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NumPorts) cand = cand - NumPorts;
            if (!any_gnt && rst_ni && req_i[cand] && eligible[cand]) begin
                gnt_o[cand] = 1'b1;
                win_idx     = PtrW'(cand);
                any_gnt     = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt)
            rr_ptr_d = (int'(win_idx) == NumPorts - 1) ? '0 : win_idx + 1'b1;
    end

    assign mem_req_o   = any_gnt;
    assign mem_we_o    = any_gnt && we_i[win_idx];
    assign mem_addr_o  = addr_i[win_idx*AddrWidth +: AddrWidth];
    assign mem_wdata_o = wdata_i[win_idx*DataWidth +: DataWidth];
    assign mem_be_o    = be_i[win_idx*BeWidth +: BeWidth];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= any_gnt;
            rid_q    <= win_idx;
        end
    end

    assign rvalid_o = rvalid_q ? (NumPorts'(1) << rid_q) : '0;
    assign rdata_o  = mem_rdata_i;

endmodule
